corr_collector: RTL

- Receives the per-pixel correspondence stream from the correspondence calculator and drops correspondences whose projected index lies outside the frame.
- Buffers surviving correspondences in a FIFO and presents them over valid/ready to the downstream residual/Jacobian stage.
- The input side has no backpressure; the FIFO absorbs downstream stalls.
- Tracks frame boundaries, counts accepted correspondences, and reports end-of-frame once everything has drained.

---
 rtl/corr_collector.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/corr_collector.sv
// Correspondence collector: bounds filter, FIFO buffer and frame tracking
// between the correspondence calculator and the residual/Jacobian stage.
package RgbdVoConfigPk;
  localparam int H_SIZE_BW     = 11;
  localparam int V_SIZE_BW     = 10;
  localparam int DATA_DEPTH_BW = 16;
endpackage

module corr_collector
  import RgbdVoConfigPk::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_BW     = 20
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_frame_start,
  input  logic                     i_frame_end,
  input  logic                     i_valid,
  input  logic [DATA_DEPTH_BW-1:0] i_depth0,
  input  logic [H_SIZE_BW-1:0]     i_idx0_x,
  input  logic [V_SIZE_BW-1:0]     i_idx0_y,
  input  logic [H_SIZE_BW-1:0]     i_idx1_x,
  input  logic [V_SIZE_BW-1:0]     i_idx1_y,
  input  logic [H_SIZE_BW-1:0]     r_hsize,
  input  logic [V_SIZE_BW-1:0]     r_vsize,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [DATA_DEPTH_BW-1:0] o_depth0,
  output logic [H_SIZE_BW-1:0]     o_idx0_x,
  output logic [V_SIZE_BW-1:0]     o_idx0_y,
  output logic [H_SIZE_BW-1:0]     o_idx1_x,
  output logic [V_SIZE_BW-1:0]     o_idx1_y,
  output logic                     o_frame_done,
  output logic [CNT_BW-1:0]        o_corr_cnt,
  output logic                     o_overflow,
  output logic                     o_seq_err,
  output logic                     o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CNT_BW-1:0] CNT_ONE = 1;
  localparam logic [CNT_BW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [DATA_DEPTH_BW-1:0] depth0;
    logic [H_SIZE_BW-1:0]     idx0_x;
    logic [V_SIZE_BW-1:0]     idx0_y;
    logic [H_SIZE_BW-1:0]     idx1_x;
    logic [V_SIZE_BW-1:0]     idx1_y;
  } corr_t;

  state_t      state;
  state_t      state_nxt;
  corr_t       mem [FIFO_DEPTH];
  corr_t       wr_data;
  corr_t       head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic empty;
  logic full;
  logic start_ok;
  logic seq_hit;
  logic in_run;
  logic in_bounds;
  logic accept;
  logic push;
  logic drop;
  logic pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // The accepted-start cycle behaves as the first RUN cycle.
  assign start_ok  = (state == IDLE) && i_frame_start;
  assign seq_hit   = (state != IDLE) && i_frame_start;
  assign in_run    = (state == RUN) || start_ok;
  assign in_bounds = (i_idx1_x < r_hsize) && (i_idx1_y < r_vsize);
  assign accept    = i_valid && in_run && in_bounds;
  assign push      = accept && !full;
  assign drop      = accept && full;
  assign pop       = !empty && i_ready;

  assign wr_data = '{
    depth0: i_depth0,
    idx0_x: i_idx0_x,
    idx0_y: i_idx0_y,
    idx1_x: i_idx1_x,
    idx1_y: i_idx1_y
  };

  assign head     = mem[rd_ptr[AW-1:0]];
  assign o_valid  = !empty;
  assign o_depth0 = head.depth0;
  assign o_idx0_x = head.idx0_x;
  assign o_idx0_y = head.idx0_y;
  assign o_idx1_x = head.idx1_x;
  assign o_idx1_y = head.idx1_y;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: frame sequencing, drain waits for an empty FIFO.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (i_frame_start) state_nxt = RUN;
      RUN:   if (i_frame_end) state_nxt = DRAIN;
      DRAIN: if (empty) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_busy       = (state != IDLE);
    o_frame_done = (state == DONE);
  end

  // FIFO storage; written only on a non-full accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // FIFO pointers with wrap bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Saturating per-frame count, restarted by an accepted start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_corr_cnt <= '0;
    end else if (start_ok) begin
      o_corr_cnt <= push ? CNT_ONE : '0;
    end else if (push && (o_corr_cnt != CNT_MAX)) begin
      o_corr_cnt <= o_corr_cnt + CNT_ONE;
    end
  end

  // Sticky error flags, cleared by an accepted start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow <= 1'b0;
      o_seq_err  <= 1'b0;
    end else if (start_ok) begin
      o_overflow <= drop;
      o_seq_err  <= 1'b0;
    end else begin
      o_overflow <= o_overflow | drop;
      o_seq_err  <= o_seq_err | seq_hit;
    end
  end

endmodule
